// File: rtl/decode_cycle.sv
// decode_cycle: RV32I decode stage with control decode, a 32x32 register file, immediate extension and the ID/EX register.
// Optional macro DECODE_RF_BYPASS_EN: a read of the register being written this cycle returns ResultW (write-through).
module decode_cycle #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            FlushE,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } immSel_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign funct7 = InstrD[31:25];
    assign rs1    = InstrD[19:15];
    assign rs2    = InstrD[24:20];
    assign rd     = InstrD[11:7];

    // funct3 -> ALU operation shared by R-type and I-ALU; anything else is not supported.
    logic       f3Legal;
    logic [2:0] f3Alu;

    always_comb begin
        f3Legal = 1'b1;
        f3Alu   = 3'b000;
        case (funct3)
            3'b000:  f3Alu = 3'b000;
            3'b111:  f3Alu = 3'b010;
            3'b110:  f3Alu = 3'b011;
            3'b010:  f3Alu = 3'b101;
            default: f3Legal = 1'b0;
        endcase
    end

    logic       regWrite;
    logic       memWrite;
    logic       jump;
    logic       branch;
    logic       aluSrc;
    logic [1:0] resultSrc;
    logic [2:0] aluControl;
    immSel_t    immSel;

    always_comb begin
        regWrite   = 1'b0;
        memWrite   = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        aluSrc     = 1'b0;
        resultSrc  = 2'b00;
        aluControl = 3'b000;
        immSel     = IMM_NONE;
        case (opcode)
            OP_LW: begin
                if (funct3 == 3'b010) begin
                    regWrite  = 1'b1;
                    aluSrc    = 1'b1;
                    resultSrc = 2'b01;
                    immSel    = IMM_I;
                end
            end
            OP_SW: begin
                if (funct3 == 3'b010) begin
                    memWrite = 1'b1;
                    aluSrc   = 1'b1;
                    immSel   = IMM_S;
                end
            end
            OP_R: begin
                // Only funct7 = 0 or the sub encoding (0100000 with funct3 = 000) are legal.
                if (f3Legal && (funct7 == 7'b0000000 ||
                               (funct7 == 7'b0100000 && funct3 == 3'b000))) begin
                    regWrite   = 1'b1;
                    aluControl = funct7[5] ? 3'b001 : f3Alu;
                end
            end
            OP_IALU: begin
                if (f3Legal) begin
                    regWrite   = 1'b1;
                    aluSrc     = 1'b1;
                    aluControl = f3Alu;
                    immSel     = IMM_I;
                end
            end
            OP_BEQ: begin
                if (funct3 == 3'b000) begin
                    branch     = 1'b1;
                    aluControl = 3'b001;
                    immSel     = IMM_B;
                end
            end
            OP_JAL: begin
                jump      = 1'b1;
                regWrite  = 1'b1;
                resultSrc = 2'b10;
                immSel    = IMM_J;
            end
            default: ;
        endcase
    end

    logic [31:0] immExt;

    always_comb begin
        immExt = 32'd0;
        case (immSel)
            IMM_I:   immExt = {{20{InstrD[31]}}, InstrD[31:20]};
            IMM_S:   immExt = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   immExt = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J:   immExt = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            default: immExt = 32'd0;
        endcase
    end

    // Register file: flops rather than RAM because every entry must clear on reset.
    logic [XLEN-1:0] regRead [NREGS];

    assign regRead[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : gRegs
            logic [XLEN-1:0] entry;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    entry <= '0;
                end else if (RegWriteW && RDW == 5'(gi)) begin
                    entry <= ResultW;
                end
            end

            assign regRead[gi] = entry;
        end
    endgenerate

    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

`ifdef DECODE_RF_BYPASS_EN
    assign rd1 = (RegWriteW && RDW != 5'd0 && RDW == rs1) ? ResultW : regRead[rs1];
    assign rd2 = (RegWriteW && RDW != 5'd0 && RDW == rs2) ? ResultW : regRead[rs2];
`else
    assign rd1 = regRead[rs1];
    assign rd2 = regRead[rs2];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ResultSrcE  <= 2'b00;
            ALUControlE <= 3'b000;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            Rs1E        <= 5'd0;
            Rs2E        <= 5'd0;
            RdE         <= 5'd0;
            PCE         <= '0;
            PCPlus4E    <= '0;
        end else if (FlushE) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ResultSrcE  <= 2'b00;
            ALUControlE <= 3'b000;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            Rs1E        <= 5'd0;
            Rs2E        <= 5'd0;
            RdE         <= 5'd0;
            PCE         <= '0;
            PCPlus4E    <= '0;
        end else begin
            RegWriteE   <= regWrite;
            MemWriteE   <= memWrite;
            JumpE       <= jump;
            BranchE     <= branch;
            ALUSrcE     <= aluSrc;
            ResultSrcE  <= resultSrc;
            ALUControlE <= aluControl;
            RD1E        <= rd1;
            RD2E        <= rd2;
            ImmExtE     <= XLEN'(immExt);
            Rs1E        <= rs1;
            Rs2E        <= rs2;
            RdE         <= rd;
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
        end
    end

endmodule
